// File: rtl/pr_dec_stream.sv
// pr_dec_stream: FIFO of 3-bit priority codes with a one-hot decode of the head entry.
// DEPTH (2, 4 or 8) sets the storage depth. Occupancy is tracked by a three-state FSM
// (EMPTY / PARTIAL / FULL) alongside an explicit count.
// Optional feature macro: PR_DEC_STICKY_MASK_EN accumulates popped one-hot bits into sticky_mask.
module pr_dec_stream #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [2:0]                 in_code,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_onehot,
    output logic [2:0]                 out_code,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_sticky,
    output logic [7:0]                 sticky_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
        $error("pr_dec_stream: DEPTH must be 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_t;

    occ_t            state, state_next;
    logic [2:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_next;
    logic            wr_en, rd_en;

    // Handshakes are formed only from registered state, so in_ready never depends on out_ready.
    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;
    assign count = count_q;

    // State register plus occupancy count and pointers; reset discards the stored codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Code storage; contents are left unreset since occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= in_code;
        end
    end

    // Next-state logic: count moves by the net of write and read, state follows the count.
    always_comb begin
        count_next = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
        if (count_next == '0)
            state_next = EMPTY;
        else if (count_next == CW'(DEPTH))
            state_next = FULL;
        else
            state_next = PARTIAL;
    end

    // FSM outputs: flow-control flags decoded from the occupancy state.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            EMPTY:   begin in_ready = 1'b1; out_valid = 1'b0; end
            PARTIAL: begin in_ready = 1'b1; out_valid = 1'b1; end
            FULL:    begin in_ready = 1'b0; out_valid = 1'b1; end
            default: begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    // Head decode: zeroed whenever nothing is stored.
    always_comb begin
        out_code   = 3'd0;
        out_onehot = 8'd0;
        if (out_valid) begin
            out_code   = mem[rd_ptr];
            out_onehot = 8'b1 << mem[rd_ptr];
        end
    end

    // Sticky overflow: any write attempt while full, held until reset.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (in_valid && !in_ready)
            overflow <= 1'b1;
    end

`ifdef PR_DEC_STICKY_MASK_EN
    // Accumulate popped one-hot bits; a clear in the same cycle as a pop wins.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_mask <= '0;
        else if (clr_sticky)
            sticky_mask <= '0;
        else if (rd_en)
            sticky_mask <= sticky_mask | out_onehot;
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_mask       = '0;
`endif

endmodule

// File: tb/tb_pr_dec_stream.sv
// Self-checking bench for pr_dec_stream: a queue scoreboard holds the codes the bench
// expects to leave the block, plus a small occupancy/overflow/sticky model.
module tb_pr_dec_stream;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_code = 3'd0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_onehot;
    logic [2:0]    out_code;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clr_sticky = 1'b0;
    logic [7:0]    sticky_mask;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] sb[$];
    int         mc;
    logic       ov_m;
    logic [7:0] sm_m;

    pr_dec_stream #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
        .out_valid(out_valid), .out_onehot(out_onehot), .out_code(out_code),
        .out_ready(out_ready), .count(count), .overflow(overflow),
        .clr_sticky(clr_sticky), .sticky_mask(sticky_mask)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; pops are scored against the queue, state against the model.
    task automatic drive_cycle(input logic v, input logic [2:0] code, input logic r, input logic clr);
        logic       wr, rd;
        logic [2:0] exp;
        @(negedge clk);
        in_valid = v; in_code = code; out_ready = r; clr_sticky = clr;
        #1;
        wr = v && (mc != DEPTH);
        rd = r && (mc != 0);
        n_checks++;
        if (in_ready !== (mc != DEPTH)) begin
            n_fail++; $display("FAIL in_ready_pre: got %b want %b", in_ready, (mc != DEPTH));
        end
        if (v && mc == DEPTH) ov_m = 1'b1;
        if (rd) begin
            exp = sb.pop_front();
            n_checks += 2;
            if (out_code !== exp) begin
                n_fail++; $display("FAIL pop_code: got %0d want %0d", out_code, exp);
            end
            if (out_onehot !== (8'b1 << exp)) begin
                n_fail++; $display("FAIL pop_onehot: got %h want %h", out_onehot, 8'b1 << exp);
            end
`ifdef PR_DEC_STICKY_MASK_EN
            if (!clr) sm_m = sm_m | (8'b1 << exp);
`endif
        end
`ifdef PR_DEC_STICKY_MASK_EN
        if (clr) sm_m = 8'h00;
`endif
        if (wr) sb.push_back(code);
        if (wr && !rd) mc++;
        if (rd && !wr) mc--;
        @(posedge clk);
        #1;
        n_checks += 5;
        if (count !== CW'(mc)) begin
            n_fail++; $display("FAIL count: got %0d want %0d", count, mc);
        end
        if (out_valid !== (mc != 0)) begin
            n_fail++; $display("FAIL out_valid: got %b want %b", out_valid, (mc != 0));
        end
        if (overflow !== ov_m) begin
            n_fail++; $display("FAIL overflow: got %b want %b", overflow, ov_m);
        end
        if (sticky_mask !== sm_m) begin
            n_fail++; $display("FAIL sticky_mask: got %h want %h", sticky_mask, sm_m);
        end
        if (mc == 0) begin
            if (out_code !== 3'd0 || out_onehot !== 8'd0) begin
                n_fail++; $display("FAIL empty_outputs: got code %0d onehot %h want 0 0", out_code, out_onehot);
            end
        end else begin
            if (out_code !== sb[0]) begin
                n_fail++; $display("FAIL head_code: got %0d want %0d", out_code, sb[0]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    endtask

    // Reset with a write and a read presented in the same cycle; both must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_code = 3'd3; out_ready = 1'b1; clr_sticky = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        mc = 0; ov_m = 1'b0; sm_m = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (count !== '0)         begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_onehot !== 8'd0)  begin n_fail++; $display("FAIL rst_onehot: got %h want 00", out_onehot); end
        if (out_code !== 3'd0)    begin n_fail++; $display("FAIL rst_code: got %0d want 0", out_code); end
        if (overflow !== 1'b0)    begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        if (sticky_mask !== 8'd0) begin n_fail++; $display("FAIL rst_sticky: got %h want 00", sticky_mask); end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 3'd5, 1'b0, 1'b0);
        n_checks += 4;
        if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_onehot !== 8'h20)  begin n_fail++; $display("FAIL single_onehot: got %h want 20", out_onehot); end
        if (out_code !== 3'd5)     begin n_fail++; $display("FAIL single_code: got %0d want 5", out_code); end
        if (count !== CW'(1))      begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_overflow();
        logic [2:0] codes [4]  = '{3'd7, 3'd0, 3'd3, 3'd6};
        logic [7:0] exp_oh [4] = '{8'h80, 8'h01, 8'h08, 8'h40};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, codes[i], 1'b0, 1'b0);
        n_checks += 2;
        if (count !== CW'(4))   begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        drive_cycle(1'b1, 3'd2, 1'b0, 1'b0);
        n_checks += 2;
        if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        if (out_code !== 3'd7)  begin n_fail++; $display("FAIL head_hold: got %0d want 7", out_code); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_onehot !== exp_oh[i]) begin
                n_fail++; $display("FAIL drain_onehot[%0d]: got %h want %h", i, out_onehot, exp_oh[i]);
            end
            drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_cycle(1'b1, 3'd1, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 3'((i + 3) % 8), 1'b1, 1'b0);
            n_checks++;
            if (count !== CW'(2)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); end
        end
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_full_rw_and_reset();
        do_reset();
        for (int i = 4; i < 8; i++) drive_cycle(1'b1, 3'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd1, 1'b1, 1'b0);
        n_checks += 3;
        if (count !== CW'(3))  begin n_fail++; $display("FAIL fullrw_count: got %0d want 3", count); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullrw_ovf: got %b want 1", overflow); end
        if (out_code !== 3'd5) begin n_fail++; $display("FAIL fullrw_head: got %0d want 5", out_code); end
        do_reset();
        n_checks += 5;
        if (count !== '0)        begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (out_onehot !== 8'd0) begin n_fail++; $display("FAIL mid_rst_onehot: got %h want 00", out_onehot); end
        if (overflow !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_empty_read();
        do_reset();
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd6, 1'b0, 1'b0);
        n_checks++;
        if (out_code !== 3'd6) begin n_fail++; $display("FAIL empty_read_head: got %0d want 6", out_code); end
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_sticky();
        logic [7:0] exp_after;
`ifdef PR_DEC_STICKY_MASK_EN
        exp_after = 8'h12;
`else
        exp_after = 8'h00;
`endif
        do_reset();
        drive_cycle(1'b1, 3'd1, 1'b0, 1'b0);
        drive_cycle(1'b1, 3'd4, 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b0);
        n_checks++;
        if (sticky_mask !== exp_after) begin n_fail++; $display("FAIL sticky_acc: got %h want %h", sticky_mask, exp_after); end
        drive_cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (sticky_mask !== 8'h00) begin n_fail++; $display("FAIL sticky_clr: got %h want 00", sticky_mask); end
        drive_cycle(1'b1, 3'd2, 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 1'b1, 1'b1);
        n_checks++;
        if (sticky_mask !== 8'h00) begin n_fail++; $display("FAIL sticky_clr_wins: got %h want 00", sticky_mask); end
    endtask

    initial begin
        mc = 0; ov_m = 1'b0; sm_m = 8'h00;
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_full_rw_and_reset();
        test_empty_read();
        test_sticky();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
